sequential_divider: RTL and testbench

- Iterative signed two's-complement divider; the inverse operation of the team's sequential Booth multiplier datapath.
- Captures dividend and divisor on a start edge and runs one restoring shift/subtract step per clock for DW cycles.
- Presents a registered quotient and remainder with a one-cycle ready pulse.
- Sits beside the multiplier in the arithmetic unit, on the same PLL-derived clock.

---
 rtl/sequential_divider.sv | 143 ++++++++++++++
 tb/tb_sequential_divider.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Iterative signed restoring divider: one shift/subtract step per clock, DW steps per operation.
// Quotient truncates toward zero, the remainder takes the dividend's sign, and fixed latency covers the error cases.
module sequential_divider #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_zero,
  output logic          overflow
);

  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIVIDE, S_FIX, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          start_prev_q;
  logic          armed_q;
  logic [DW-1:0] dvd_q, dvs_q;
  logic          neg_dvd_q, neg_dvs_q;
  logic [DW-1:0] mag_dvs_q;
  logic [DW-1:0] pr_q;
  logic [DW-1:0] qr_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quotient_q, remainder_q;
  logic          div_zero_q, overflow_q;

  logic          start_edge;
  logic [DW:0]   shifted;
  logic [DW:0]   trial;
  logic [DW-1:0] mag_dvd, mag_dvs;
  logic [DW-1:0] quo_fix, rem_fix;
  logic          dz_fix, ov_fix;

  // armed_q keeps a start level held through reset release from counting as an edge
  assign start_edge = start && !start_prev_q && armed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_edge) state_d = S_LOAD;
      S_LOAD:   state_d = S_DIVIDE;
      S_DIVIDE: if (cnt_q == CW'(DW-1)) state_d = S_FIX;
      S_FIX:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mag_dvd = dvd_q[DW-1] ? (~dvd_q + 1'b1) : dvd_q;
  assign mag_dvs = dvs_q[DW-1] ? (~dvs_q + 1'b1) : dvs_q;
  assign shifted = {pr_q, qr_q[DW-1]};
  assign trial   = shifted - {1'b0, mag_dvs_q};

  // Overflow needs no special case: magnitude 2^(DW-1) with equal signs wraps to MIN_VAL
  always_comb begin
    dz_fix  = (dvs_q == '0);
    ov_fix  = (dvd_q == MIN_VAL) && (dvs_q == '1);
    quo_fix = (neg_dvd_q ^ neg_dvs_q) ? (~qr_q + 1'b1) : qr_q;
    rem_fix = neg_dvd_q ? (~pr_q + 1'b1) : pr_q;
    if (dz_fix) begin
      quo_fix = '0;
      rem_fix = dvd_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      neg_dvd_q    <= 1'b0;
      neg_dvs_q    <= 1'b0;
      mag_dvs_q    <= '0;
      pr_q         <= '0;
      qr_q         <= '0;
      cnt_q        <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      div_zero_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      start_prev_q <= start;
      if (!start) armed_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
          end
        end
        S_LOAD: begin
          neg_dvd_q <= dvd_q[DW-1];
          neg_dvs_q <= dvs_q[DW-1];
          qr_q      <= mag_dvd;
          mag_dvs_q <= mag_dvs;
          pr_q      <= '0;
          cnt_q     <= '0;
        end
        S_DIVIDE: begin
          // A kept partial remainder is below the divisor magnitude, so DW bits hold it
          if (!trial[DW]) begin
            pr_q <= trial[DW-1:0];
            qr_q <= {qr_q[DW-2:0], 1'b1};
          end else begin
            pr_q <= shifted[DW-1:0];
            qr_q <= {qr_q[DW-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          quotient_q  <= quo_fix;
          remainder_q <= rem_fix;
          div_zero_q  <= dz_fix;
          overflow_q  <= ov_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == S_LOAD) || (state_q == S_DIVIDE) || (state_q == S_FIX);
  assign ready     = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed vector bench for sequential_divider (DW=16): results, flags, latency, start handling, reset.
module tb_sequential_divider;

  localparam int DW  = 16;
  localparam int LAT = DW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [DW-1:0] divisor = '0;
  logic          busy, ready, div_zero, overflow;
  logic [DW-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  sequential_divider #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .ready(ready),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic          ov;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Launch one division; returns the number of rising edges from the start edge to ready.
  task automatic run_div(input logic [DW-1:0] a, input logic [DW-1:0] b, output int lat);
    bit seen_busy;
    lat = 0;
    seen_busy = 0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        seen_busy = busy;
        // operands must already be captured; these changes must be ignored
        dividend = 16'h1357; divisor = 16'h0003; start = 1'b0;
      end
      if (ready) break;
    end
    check("busy_after_start", {31'd0, seen_busy}, 32'd1);
    if (lat >= 60) check("ready_timeout", 32'd0, 32'd1);
    else check("busy_low_in_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("ready_one_cycle", {31'd0, ready}, 32'd0);
  endtask

  int lat;
  int pulses;

  initial begin
    vecs[0]  = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0};
    vecs[1]  = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{16'd9,    16'd3,    16'd3,    16'd0,    1'b0, 1'b0};
    vecs[5]  = '{16'd5,    16'd0,    16'd0,    16'd5,    1'b1, 1'b0};
    vecs[6]  = '{16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 1'b0};
    vecs[7]  = '{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0};
    vecs[8]  = '{16'h8000, 16'd1,    16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[10] = '{16'hFFFB, 16'd0,    16'd0,    16'hFFFB, 1'b1, 1'b0};
    vecs[11] = '{16'd1234, 16'd5,    16'd246,  16'd4,    1'b0, 1'b0};

    // reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {16'd0, remainder}, 32'd0);
    check("rst_flags", {30'd0, div_zero, overflow}, 32'd0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      $display("vec %0d: 0x%h / 0x%h -> q=0x%h r=0x%h dz=%0b ov=%0b lat=%0d",
               i, vecs[i].a, vecs[i].b, quotient, remainder, div_zero, overflow, lat);
      check("latency", lat, LAT);
      check("quotient", {16'd0, quotient}, {16'd0, vecs[i].q});
      check("remainder", {16'd0, remainder}, {16'd0, vecs[i].r});
      check("div_zero", {31'd0, div_zero}, {31'd0, vecs[i].dz});
      check("overflow", {31'd0, overflow}, {31'd0, vecs[i].ov});
    end

    // start held high for 40 cycles: one operation only
    @(negedge clk); start = 1'b0;
    @(negedge clk); dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (ready) pulses++; end
    start = 1'b0;
    $display("held start: ready pulses=%0d q=0x%h", pulses, quotient);
    check("held_start_pulses", pulses, 1);
    check("held_start_quotient", {16'd0, quotient}, 32'd14);

    // second pulse while busy is dropped
    @(negedge clk); dividend = 16'd9; divisor = 16'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    pulses = 0;
    repeat (45) begin @(negedge clk); if (ready) pulses++; end
    $display("pulse while busy: ready pulses=%0d q=0x%h", pulses, quotient);
    check("busy_pulse_count", pulses, 1);
    check("busy_pulse_quotient", {16'd0, quotient}, 32'd3);

    // reset in the middle of DIVIDE, start held through release
    @(negedge clk); dividend = 16'd1234; divisor = 16'd5; start = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("midop_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); rst = 1'b0;
    #1;
    $display("mid-op reset: busy=%0b ready=%0b q=0x%h r=0x%h", busy, ready, quotient, remainder);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_quotient", {16'd0, quotient}, 32'd0);
    check("midrst_remainder", {16'd0, remainder}, 32'd0);
    check("midrst_flags", {30'd0, div_zero, overflow}, 32'd0);
    @(negedge clk); rst = 1'b1;
    pulses = 0;
    repeat (30) begin @(negedge clk); if (ready || busy) pulses++; end
    check("held_after_reset_no_launch", pulses, 0);
    run_div(16'd1234, 16'd5, lat);
    $display("after reset: 1234 / 5 -> q=0x%h r=0x%h lat=%0d", quotient, remainder, lat);
    check("post_rst_latency", lat, LAT);
    check("post_rst_quotient", {16'd0, quotient}, 32'd246);
    check("post_rst_remainder", {16'd0, remainder}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
